// File: rtl/stage_instruction_fetch_buffered.sv
// Buffered instruction fetch stage.
// Keeps up to DEPTH fetches outstanding against a variable-latency memory,
// pairs each returned word with its PC in an in-order queue and presents the
// queue head to decode. An execute redirect restarts fetch at the target and
// silently discards responses still owed for wrong-path requests.
module stage_instruction_fetch_buffered #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_pc_src,
  input  logic [XLEN-1:0] ex_pc_target,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_rsp_valid,
  input  logic [XLEN-1:0] if_rsp_data,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [XLEN-1:0] de_instr,
  output logic [XLEN-1:0] de_pc,
  output logic [XLEN-1:0] de_pc_plus4
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam int unsigned     PW      = AW + 1;
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);
  localparam logic [PW:0]     DEPTH_W = DEPTH[PW:0];

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [PW-1:0]   alloc;
  logic [PW-1:0]   fill;
  logic [PW-1:0]   rd;
  logic [PW-1:0]   drop;

  // Head contents of the most recently consumed entry, shown while empty.
  logic [XLEN-1:0] last_instr;
  logic [XLEN-1:0] last_pc;
  logic [XLEN-1:0] last_pc_plus4;

  logic [PW-1:0]   occupancy;
  logic [PW-1:0]   pending;
  logic [PW:0]     budget;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_fill;
  logic            pop;
  logic [PW-1:0]   drop_redirect;
  logic [AW-1:0]   rd_idx;
  logic [AW-1:0]   alloc_idx;
  logic [AW-1:0]   fill_idx;

  // Queue bookkeeping, request gating and head presentation.
  always_comb begin
    occupancy     = alloc - rd;
    pending       = alloc - fill;
    budget        = {1'b0, occupancy} + {1'b0, drop};
    if_req_valid  = ~rst & (budget < DEPTH_W);
    if_req_addr   = fetch_pc;
    req_fire      = if_req_valid & if_req_ready;
    rsp_drop      = if_rsp_valid & (drop != '0);
    // A response with nothing owed is a protocol violation and is ignored.
    rsp_fill      = if_rsp_valid & (drop == '0) & (pending != '0);
    de_valid      = (fill != rd);
    pop           = de_valid & de_ready;
    rd_idx        = rd[AW-1:0];
    alloc_idx     = alloc[AW-1:0];
    fill_idx      = fill[AW-1:0];
    // Everything owed by memory after this edge belongs to the old path:
    // pending plus a request accepted now, minus a response arriving now.
    drop_redirect = drop + pending + PW'(req_fire) - PW'(rsp_drop | rsp_fill);
    if (de_valid) begin
      de_instr    = instr_q[rd_idx];
      de_pc       = pc_q[rd_idx];
      de_pc_plus4 = pc_q[rd_idx] + STEP;
    end else begin
      de_instr    = last_instr;
      de_pc       = last_pc;
      de_pc_plus4 = last_pc_plus4;
    end
  end

  // Entry storage: PC captured on request acceptance, word on response.
  always_ff @(posedge clk) begin
    if (!ex_pc_src) begin
      if (req_fire) pc_q[alloc_idx] <= fetch_pc;
      if (rsp_fill) instr_q[fill_idx] <= if_rsp_data;
    end
  end

  // Fetch PC, queue pointers, drop counter and held head contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc      <= RESET_PC;
      alloc         <= '0;
      fill          <= '0;
      rd            <= '0;
      drop          <= '0;
      last_instr    <= '0;
      last_pc       <= '0;
      last_pc_plus4 <= '0;
    end else if (ex_pc_src) begin
      fetch_pc <= {ex_pc_target[XLEN-1:2], 2'b00};
      alloc    <= '0;
      fill     <= '0;
      rd       <= '0;
      drop     <= drop_redirect;
    end else begin
      if (req_fire) begin
        alloc    <= alloc + 1'b1;
        fetch_pc <= fetch_pc + STEP;
      end
      if (rsp_drop) drop <= drop - 1'b1;
      if (rsp_fill) fill <= fill + 1'b1;
      if (pop) begin
        rd            <= rd + 1'b1;
        last_instr    <= de_instr;
        last_pc       <= de_pc;
        last_pc_plus4 <= de_pc_plus4;
      end
    end
  end

endmodule

// File: tb/tb_stage_instruction_fetch_buffered.sv
// Directed and randomized bench for the buffered fetch stage with an
// in-order variable-latency memory model and an expected-PC scoreboard.
module tb_stage_instruction_fetch_buffered;

  logic        clk;
  logic        rst;
  logic        ex_pc_src;
  logic [31:0] ex_pc_target;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        de_valid;
  logic        de_ready;
  logic [31:0] de_instr;
  logic [31:0] de_pc;
  logic [31:0] de_pc_plus4;

  stage_instruction_fetch_buffered #(
    .XLEN    (32),
    .DEPTH   (4),
    .RESET_PC(32'h0),
    .PC_STEP (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_pc_src   (ex_pc_src),
    .ex_pc_target(ex_pc_target),
    .if_req_valid(if_req_valid),
    .if_req_ready(if_req_ready),
    .if_req_addr (if_req_addr),
    .if_rsp_valid(if_rsp_valid),
    .if_rsp_data (if_rsp_data),
    .de_valid    (de_valid),
    .de_ready    (de_ready),
    .de_instr    (de_instr),
    .de_pc       (de_pc),
    .de_pc_plus4 (de_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    longint      due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  int unsigned ready_pct = 100;
  int unsigned de_ready_pct = 100;
  logic [31:0] model_pc = 32'h0;
  int          req_count = 0;
  int          pop_count = 0;
  logic [31:0] last_pop_pc = 32'h0;
  logic        s_de_valid, s_fire, s_rsp;
  logic [31:0] s_req_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: starts just after a falling edge, drives inputs,
  // samples outputs, updates the models, ends on the next falling edge.
  task automatic step(input logic redir, input logic [31:0] tgt);
    logic        fire;
    logic        pop;
    logic [31:0] e;
    longint      d;
    if_req_ready = ($urandom_range(99) < ready_pct);
    de_ready     = ($urandom_range(99) < de_ready_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      if_rsp_valid = 1'b1;
      if_rsp_data  = mq[0].addr ^ 32'h0000A5A5;
    end else begin
      if_rsp_valid = 1'b0;
      if_rsp_data  = '0;
    end
    ex_pc_src    = redir;
    ex_pc_target = tgt;
    #1;
    fire       = if_req_valid & if_req_ready;
    pop        = de_valid & de_ready;
    s_de_valid = de_valid;
    s_fire     = fire;
    s_rsp      = if_rsp_valid;
    s_req_addr = if_req_addr;
    if (pop && !redir) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_pop observed_pc=%h expected=none", de_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("de_pc", de_pc, e);
        chk("de_instr", de_instr, e ^ 32'h0000A5A5);
        chk("de_pc_plus4", de_pc_plus4, e + 32'd4);
        pop_count++;
        last_pop_pc = de_pc;
      end
    end
    if (if_rsp_valid) void'(mq.pop_front());
    if (fire) begin
      chk("req_addr", if_req_addr, model_pc);
      d = cyc + longint'($urandom_range(lat_max, lat_min));
      if (mq.size() > 0 && d < mq[mq.size()-1].due) d = mq[mq.size()-1].due;
      mq.push_back('{addr: if_req_addr, due: d});
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
      req_count++;
    end
    if (redir) begin
      exp_q.delete();
      model_pc = tgt & ~32'h3;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_pop(input string tag);
    int p0;
    p0 = pop_count;
    for (int i = 0; i < 40 && pop_count == p0; i++) step(1'b0, 32'h0);
    chk(tag, 32'(pop_count > p0), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    mq.delete();
    exp_q.delete();
    model_pc = 32'h0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int r0;
    int p0;
    rst          = 1'b1;
    ex_pc_src    = 1'b0;
    ex_pc_target = '0;
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    de_ready     = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_valid", 32'(if_req_valid), 32'd0);
    chk("rst_de_valid", 32'(de_valid), 32'd0);
    chk("rst_req_addr", if_req_addr, 32'h0);
    chk("rst_de_pc", de_pc, 32'h0);
    chk("rst_de_instr", de_instr, 32'h0);
    chk("rst_de_pc_plus4", de_pc_plus4, 32'h0);

    // 1-cycle memory streaming: request N, response N+1, de_valid N+2
    rst = 1'b0;
    step(1'b0, 32'h0);
    chk("first_req_fire", 32'(s_fire), 32'd1);
    chk("first_req_addr", s_req_addr, 32'h0);
    chk("lat_de_valid_c0", 32'(s_de_valid), 32'd0);
    step(1'b0, 32'h0);
    chk("lat_de_valid_c1", 32'(s_de_valid), 32'd0);
    step(1'b0, 32'h0);
    chk("lat_de_valid_c2", 32'(s_de_valid), 32'd1);
    chk("first_pop_pc", last_pop_pc, 32'h0);
    p0 = pop_count;
    repeat (30) step(1'b0, 32'h0);
    chk("throughput_30", 32'(pop_count - p0), 32'd30);

    // Decode stall: exactly DEPTH requests, head held, then drained in order
    do_reset();
    rst = 1'b0;
    de_ready_pct = 0;
    r0 = req_count;
    repeat (10) step(1'b0, 32'h0);
    chk("stall_req_count", 32'(req_count - r0), 32'd4);
    chk("stall_req_valid", 32'(if_req_valid), 32'd0);
    chk("stall_de_valid", 32'(de_valid), 32'd1);
    chk("stall_head_pc", de_pc, 32'h0);
    de_ready_pct = 100;
    p0 = pop_count;
    repeat (8) step(1'b0, 32'h0);
    chk("stall_drain", 32'(pop_count - p0 >= 4), 32'd1);

    // 3-cycle memory, redirect with three wrong-path responses owed
    lat_min = 3;
    lat_max = 3;
    repeat (12) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0103);
    step(1'b0, 32'h0);
    chk("redir_req_fire", 32'(s_fire), 32'd1);
    chk("redir_req_addr", s_req_addr, 32'h0000_0100);
    chk("redir_gap_n1", 32'(s_de_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0);
      chk("redir_gap", 32'(s_de_valid), 32'd0);
    end
    run_until_pop("redir_pop_seen");
    chk("redir_first_pc", last_pop_pc, 32'h0000_0100);

    // Redirect coinciding with an accepted request and a response
    lat_min = 1;
    lat_max = 1;
    repeat (8) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0200);
    chk("redir2_fire", 32'(s_fire), 32'd1);
    chk("redir2_rsp", 32'(s_rsp), 32'd1);
    run_until_pop("redir2_pop_seen");
    chk("redir2_first_pc", last_pop_pc, 32'h0000_0200);

    // Random ready and latency 1..5, 1000 instructions
    lat_min = 1;
    lat_max = 5;
    ready_pct = 60;
    de_ready_pct = 70;
    p0 = pop_count;
    for (int i = 0; i < 10000 && (pop_count - p0) < 1000; i++) step(1'b0, 32'h0);
    chk("random_1000_done", 32'(pop_count - p0 >= 1000), 32'd1);

    // Reset mid-stream with requests in flight
    lat_min = 3;
    lat_max = 3;
    ready_pct = 100;
    de_ready_pct = 100;
    repeat (10) step(1'b0, 32'h0);
    chk("prereset_de_valid", 32'(s_de_valid), 32'd1);
    chk("prereset_inflight", 32'(mq.size() >= 2), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_req_valid", 32'(if_req_valid), 32'd0);
    chk("midrst_de_valid", 32'(de_valid), 32'd0);
    mq.delete();
    exp_q.delete();
    model_pc = 32'h0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    step(1'b0, 32'h0);
    chk("restart_fire", 32'(s_fire), 32'd1);
    chk("restart_addr", s_req_addr, 32'h0);
    run_until_pop("restart_pop_seen");
    chk("restart_first_pc", last_pop_pc, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
